// File: rtl/dmem_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
// Both channels: a transfer happens on a rising edge where valid and ready are both 1;
// valid never depends combinationally on ready, and payload is stable while valid waits.
interface dmem_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [2:0]            req_wid_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wid_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wid_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Little-endian byte-addressed data memory with a fixed number of wait states,
// one outstanding request, and error responses for bad alignment/width/range.
module dmem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int MAXB  = (DATA_WIDTH / 8 < 8) ? DATA_WIDTH / 8 : 8;
  localparam int RW    = (DATA_WIDTH > 64) ? DATA_WIDTH : 64;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  ready_q;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [2:0]            lat_wid;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic [7:0]            mem [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [2:0]            cur_wid;
  logic [3:0]            size;
  logic                  misaligned;
  logic                  illegal;
  logic                  out_of_range;
  logic                  op_err;
  logic [ADDR_WIDTH:0]   end_addr;
  logic [RW-1:0]         raw;
  logic                  sign_bit;
  logic                  sext;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] op_rdata;

  assign bus.req_ready_o = ready_q & ~rst_i;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign dbg_state       = state;

  assign accept = bus.req_valid_i & bus.req_ready_o;

  // With zero wait states the operation executes on the accepting edge, so it
  // must come straight from the bus; otherwise from the latched copy.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_wid   = lat_wid;
    if (state == IDLE) begin
      cur_we    = bus.req_we_i;
      cur_addr  = bus.req_addr_i;
      cur_wdata = bus.req_wdata_i;
      cur_wid   = bus.req_wid_i;
    end
  end

  assign commit = ~rst_i &
                  (((state == IDLE) & accept & (LATENCY == 0)) |
                   ((state == WAIT) & (cnt == 4'd1)));

  always_comb begin
    size       = 4'd8;
    misaligned = 1'b0;
    case (cur_wid[1:0])
      2'b00: size = 4'd1;
      2'b01: begin
        size       = 4'd2;
        misaligned = cur_addr[0];
      end
      2'b10: begin
        size       = 4'd4;
        misaligned = |cur_addr[1:0];
      end
      default: begin
        size       = 4'd8;
        misaligned = |cur_addr[2:0];
      end
    endcase
  end

  assign illegal      = (cur_wid == 3'b111) | (cur_we & cur_wid[2]) |
                        (int'(size) * 8 > DATA_WIDTH);
  assign end_addr     = {1'b0, cur_addr} + (ADDR_WIDTH + 1)'(size);
  assign out_of_range = end_addr > (ADDR_WIDTH + 1)'(DEPTH);
  assign op_err       = misaligned | illegal | out_of_range;

  always_comb begin
    raw = '0;
    for (int i = 0; i < MAXB; i++) begin
      if (4'(i) < size) raw[8*i +: 8] = mem[cur_addr + ADDR_WIDTH'(i)];
    end
  end

  always_comb begin
    sign_bit = 1'b0;
    case (size)
      4'd1:    sign_bit = raw[7];
      4'd2:    sign_bit = raw[15];
      4'd4:    sign_bit = raw[31];
      default: sign_bit = 1'b0;
    endcase
    sext = ~cur_wid[2] & (size != 4'd8);
    ld_data = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      ld_data[j] = (j < int'(size) * 8) ? raw[j] : (sext & sign_bit);
    end
  end

  assign op_rdata = (cur_we | op_err) ? '0 : ld_data;

  // Memory is deliberately outside reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (commit & cur_we & ~op_err) begin
      for (int i = 0; i < MAXB; i++) begin
        if (4'(i) < size) mem[cur_addr + ADDR_WIDTH'(i)] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ready_q     <= 1'b1;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wid     <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= bus.req_we_i;
            lat_addr  <= bus.req_addr_i;
            lat_wdata <= bus.req_wdata_i;
            lat_wid   <= bus.req_wid_i;
            cnt       <= 4'(LATENCY);
            ready_q   <= 1'b0;
            if (LATENCY == 0) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= op_rdata;
              rsp_err_q   <= op_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state       <= RESP;
            cnt         <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= op_rdata;
            rsp_err_q   <= op_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // ready rises only after the handshake edge, never alongside it
          if (bus.rsp_ready_i) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) checked
// against a byte-array reference model, with directed and random accesses.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        req_valid [3];
  logic        req_we    [3];
  logic [11:0] req_addr  [3];
  logic [63:0] req_wdata [3];
  logic [2:0]  req_wid   [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [63:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic [1:0]  dbg       [3];

  int lat_tab [3] = '{0, 1, 3};

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    dmem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(12)) bus_if ();
    assign bus_if.req_valid_i = req_valid[g];
    assign bus_if.req_we_i    = req_we[g];
    assign bus_if.req_addr_i  = req_addr[g];
    assign bus_if.req_wdata_i = req_wdata[g];
    assign bus_if.req_wid_i   = req_wid[g];
    assign bus_if.rsp_ready_i = rsp_ready[g];
    assign req_ready[g] = bus_if.req_ready_o;
    assign rsp_valid[g] = bus_if.rsp_valid_o;
    assign rsp_rdata[g] = bus_if.rsp_rdata_o;
    assign rsp_err[g]   = bus_if.rsp_err_o;
    dmem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .LATENCY(L)) dut (
      .clk_i     (clk),
      .rst_i     (rst[g]),
      .bus       (bus_if.slave),
      .dbg_state (dbg[g])
    );
  end

  // Reference memory: one byte array per instance.
  logic [7:0] mdl [3][4096];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int i, input bit we, input logic [11:0] addr,
                                input logic [63:0] wd, input logic [2:0] wid,
                                output bit err, output logic [63:0] rd);
    int sz = 1 << wid[1:0];
    int a = int'(addr);
    logic [63:0] v = 64'd0;
    err = (wid == 3'b111) || (we && wid[2]) || (a % sz != 0) || (a + sz > 4096);
    rd = 64'd0;
    if (err) return;
    for (int b = 0; b < sz; b++) begin
      if (we) mdl[i][a + b] = wd[8*b +: 8];
      else    v = v | (64'(mdl[i][a + b]) << (8 * b));
    end
    if (!we) begin
      if (!wid[2] && sz < 8 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
      rd = v;
    end
  endfunction

  task automatic junk(input int i);
    req_we[i]    = 1'($urandom_range(0, 1));
    req_addr[i]  = 12'($urandom);
    req_wdata[i] = {$urandom, $urandom};
    req_wid[i]   = 3'($urandom_range(0, 7));
  endtask

  task automatic do_txn(input int i, input bit we, input logic [11:0] addr,
                        input logic [63:0] wd, input logic [2:0] wid, input int stall,
                        output logic [63:0] rd, output logic er);
    bit          exp_err;
    logic [63:0] exp_rd;
    int          k;
    int          t;
    model(i, we, addr, wd, wid, exp_err, exp_rd);
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    req_wid[i]   = wid;
    t = 0;
    while (!req_ready[i] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[i]) begin
      check("ready_timeout", 64'(req_ready[i]), 64'd1);
      req_valid[i] = 1'b0;
      rd = '0;
      er = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    junk(i);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (rsp_valid[i]) break;
      check("busy_ready", 64'(req_ready[i]), 64'd0);
    end
    check("latency", 64'(k), 64'(lat_tab[i] + 1));
    rd = rsp_rdata[i];
    er = rsp_err[i];
    check("rdata", rd, exp_rd);
    check("err", 64'(er), 64'(exp_err));
    for (int s = 0; s < stall; s++) begin
      req_valid[i] = 1'b1;
      junk(i);
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid[i]), 64'd1);
      check("hold_rdata", rsp_rdata[i], exp_rd);
      check("hold_err", 64'(rsp_err[i]), 64'(exp_err));
      check("hold_ready", 64'(req_ready[i]), 64'd0);
    end
    // Offer a request during the handshake cycle; it must not be taken.
    req_valid[i] = 1'b1;
    junk(i);
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[i] = 1'b0;
    req_valid[i] = 1'b0;
    @(negedge clk);
    check("post_valid", 64'(rsp_valid[i]), 64'd0);
    check("post_ready", 64'(req_ready[i]), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    for (int i = 0; i < 3; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_wid[i]   = '0;
      rsp_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 64'(req_ready[i]), 64'd0);
      check("rst_valid", 64'(rsp_valid[i]), 64'd0);
      check("rst_rdata", rsp_rdata[i], 64'd0);
      check("rst_err", 64'(rsp_err[i]), 64'd0);
      rst[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) check("rel_ready", 64'(req_ready[i]), 64'd1);

    // Give both test windows known contents.
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < 128; a += 8) begin
        do_txn(i, 1'b1, 12'(a), {$urandom, $urandom}, 3'b011, 0, rd, er);
        do_txn(i, 1'b1, 12'(12'hF80 + a), {$urandom, $urandom}, 3'b011, 0, rd, er);
      end
    end

    // Directed accesses, one wait state.
    do_txn(1, 1'b1, 12'h010, 64'h8877665544332211, 3'b011, 0, rd, er);
    check("sd_err", 64'(er), 64'd0);
    check("sd_rdata", rd, 64'd0);
    do_txn(1, 1'b0, 12'h017, 64'd0, 3'b000, 0, rd, er);
    check("lb_017", rd, 64'hFFFFFFFFFFFFFF88);
    do_txn(1, 1'b0, 12'h017, 64'd0, 3'b100, 0, rd, er);
    check("lbu_017", rd, 64'h0000000000000088);
    do_txn(1, 1'b0, 12'h010, 64'd0, 3'b101, 0, rd, er);
    check("lhu_010", rd, 64'h0000000000002211);
    do_txn(1, 1'b0, 12'h014, 64'd0, 3'b010, 0, rd, er);
    check("lw_014", rd, 64'hFFFFFFFF88776655);
    do_txn(1, 1'b1, 12'h000, 64'h0123456789ABCDEF, 3'b011, 0, rd, er);
    do_txn(1, 1'b0, 12'h006, 64'd0, 3'b010, 0, rd, er);
    check("lw_mis_err", 64'(er), 64'd1);
    check("lw_mis_rdata", rd, 64'd0);
    do_txn(1, 1'b1, 12'h003, 64'h000000000000BEEF, 3'b001, 0, rd, er);
    check("sh_mis_err", 64'(er), 64'd1);
    do_txn(1, 1'b0, 12'h000, 64'd0, 3'b011, 0, rd, er);
    check("ld_000_kept", rd, 64'h0123456789ABCDEF);
    do_txn(1, 1'b0, 12'h010, 64'd0, 3'b111, 0, rd, er);
    check("wid7_err", 64'(er), 64'd1);
    do_txn(1, 1'b1, 12'h010, 64'hFF, 3'b100, 0, rd, er);
    check("sbu_err", 64'(er), 64'd1);
    do_txn(1, 1'b0, 12'h010, 64'd0, 3'b011, 5, rd, er);
    check("bp_ld", rd, 64'h8877665544332211);
    do_txn(1, 1'b1, 12'hFF8, 64'hA5A5A5A5DEADBEEF, 3'b011, 0, rd, er);
    check("sd_ff8_err", 64'(er), 64'd0);
    do_txn(1, 1'b1, 12'hFFC, 64'h1, 3'b011, 0, rd, er);
    check("sd_ffc_err", 64'(er), 64'd1);
    do_txn(1, 1'b1, 12'hFFC, 64'hCAFEF00D, 3'b010, 0, rd, er);
    check("sw_ffc_err", 64'(er), 64'd0);
    do_txn(1, 1'b0, 12'hFFC, 64'd0, 3'b110, 0, rd, er);
    check("lwu_ffc", rd, 64'h00000000CAFEF00D);
    do_txn(1, 1'b0, 12'hFF8, 64'd0, 3'b011, 0, rd, er);
    check("ld_ff8", rd, 64'hCAFEF00DDEADBEEF);

    // Reset in the second wait cycle of a three-wait-state store.
    do_txn(2, 1'b1, 12'h020, 64'h1122334455667788, 3'b011, 0, rd, er);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 12'h020;
    req_wdata[2] = 64'h1;
    req_wid[2]   = 3'b011;
    check("abort_ready", 64'(req_ready[2]), 64'd1);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    check("abort_rst_ready", 64'(req_ready[2]), 64'd0);
    check("abort_rst_valid", 64'(rsp_valid[2]), 64'd0);
    @(negedge clk);
    check("abort_rst_rdata", rsp_rdata[2], 64'd0);
    check("abort_rst_err", 64'(rsp_err[2]), 64'd0);
    rst[2] = 1'b0;
    #1;
    check("abort_rel_ready", 64'(req_ready[2]), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid[2]), 64'd0);
    end
    do_txn(2, 1'b0, 12'h020, 64'd0, 3'b011, 0, rd, er);
    check("abort_ld", rd, 64'h1122334455667788);

    // Random traffic inside the known windows.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 60; n++) begin
        logic [2:0] wid;
        int         sz;
        int         off;
        int         base;
        wid  = 3'($urandom_range(0, 7));
        sz   = 1 << wid[1:0];
        base = ($urandom_range(0, 1) == 0) ? 0 : 12'hF80;
        off  = $urandom_range(0, 127);
        if ($urandom_range(0, 3) != 0) off = off - (off % sz);
        do_txn(i, 1'($urandom_range(0, 1)), 12'(base + off), {$urandom, $urandom},
               wid, $urandom_range(0, 2), rd, er);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
